sha256_block_sequencer: RTL
===========================

Name: sha256_block_sequencer

Overview:
Multi-block SHA-256 compression engine with runtime chaining and a folded round datapath. It accepts 512-bit padded message blocks over a valid/ready handshake and runs 64 rounds at ROUNDS_PER_CYCLE rounds per clock. It chains the intermediate hash across blocks and presents the final 256-bit digest over a second valid/ready handshake. It supersedes the fixed single-pass math core by adding message streaming, chaining, backpressure and a selectable fold factor.

Parameters:
ROUNDS_PER_CYCLE, 1, rounds unrolled per clock; legal values 1, 2, 4, 8, 16; other values are a elaboration-time error.
RUN_CYCLES, 64/ROUNDS_PER_CYCLE, derived local constant; not overridable.

Ports:
clk  in  1  single clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
blk_valid  in  1  a block is offered.
blk_ready  out  1  engine can accept a block.
blk_data  in  512  padded message block; word W0 in bits [511:480].
blk_first  in  1  block starts a new message; chaining state loads from H0 constants.
blk_last  in  1  block ends the message; a digest is produced after it.
dig_valid  out  1  digest is available.
dig_ready  in  1  consumer accepts the digest.
dig_data  out  256  digest; H0 in bits [255:224].
busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, reset_n=0): state=IDLE, blk_ready=1, dig_valid=0, dig_data=0, busy=0, chaining H=0, round counter=0.
- State IDLE:
  - blk_ready=1.
  - On a handshake (blk_valid&&blk_ready) at edge t:
    - latch blk_data into the 16-word schedule window;
    - set the working vars a..h to H0 constants if blk_first, else to the current H;
    - the same value also loads the chaining register H;
    - latch blk_last;
    - go to RUN.
- State RUN:
  - blk_ready=0.
  - Each cycle applies ROUNDS_PER_CYCLE rounds.
  - The schedule window shifts by ROUNDS_PER_CYCLE words per cycle.
  - The round counter increments by ROUNDS_PER_CYCLE.
  - After RUN_CYCLES cycles, go to FINAL.
- State FINAL (1 cycle):
  - H[i] <= H[i] + var[i] mod 2^32 for each of the 8 words.
  - If last: dig_data <= the summed H, dig_valid <= 1, go to OUT.
  - Otherwise go to IDLE.
- State OUT:
  - dig_valid=1 and dig_data held stable until dig_ready.
  - blk_ready=0, so no new block is accepted while the digest is pending.
  - On dig_valid&&dig_ready: dig_valid <= 0, go to IDLE.
- Latency:
  - Handshake edge t → dig_valid high after edge t+RUN_CYCLES+1.
  - That is 65 cycles for R=1 and 17 cycles for R=4.
  - Back-to-back throughput: 1 block per RUN_CYCLES+2 cycles.
- Arithmetic: all additions are 32-bit modulo 2^32. Σ0, Σ1, σ0, σ1, Ch and Maj follow FIPS 180-4.
- Schedule: W[j] for j≥16 is generated on the fly from the 16-word window; no 64-word storage.
- Boundary cases:
  - blk_first=1 on a middle block discards the prior chaining state; this is legal.
  - blk_first=0 on the first block after reset chains from H=0; this is defined but meaningless.
  - blk_first and blk_last both set gives a single-block message.
  - blk_valid in RUN/FINAL/OUT is ignored; the producer must hold it.
  - dig_ready while dig_valid=0 has no effect.
  - reset_n low mid-RUN or in OUT aborts immediately to the reset values; a partial digest is never emitted.

Decomposition:
- Shared package sha256_pkg holds:
  - the K[0:63] round-constant array;
  - the H0 initial-hash constant (256'h6a09e667…5be0cd19);
  - the state enum {IDLE, RUN, FINAL, OUT};
  - functions for Σ0, Σ1, σ0, σ1, Ch and Maj.
- One sub-module, sha256_round: purely combinational single round taking (a..h, W, K) and producing next a..h. It is instantiated ROUNDS_PER_CYCLE times in a generate chain.

Test Plan:
- "abc", R=1: blk_data=512'h61626380…0018, first=1, last=1, dig_ready=1 → dig_data=BA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD, dig_valid exactly 65 cycles after the handshake.
- Two-block "abcdbcdecdef…nopq", R=4:
  - block1 first=1, last=0; block2 first=0, last=1.
  - No digest is produced after block1.
  - Final dig_data=248D6A61D20638B8E5C026930C3E6039A33CE45964FF2167F6ECEDD419DB06C1.
  - Observed intermediate H after block1 (via a hierarchy probe)=85E655D6417A17953363376A624CDE5C76E09589CAC5F811CC4B32C1F20E533A.
- Backpressure: "abc" with dig_ready=0 for 20 cycles:
  - dig_valid and dig_data stay stable;
  - blk_ready=0 while a second offered block is held;
  - the second block is accepted the cycle after dig_ready=1.
- Reset mid-RUN: assert reset_n=0 at cycle 10 of the "abc" run → all outputs return to reset values asynchronously. Re-running "abc" afterwards gives the correct digest.
- Sweep R∈{1,2,8,16} on "abc" → identical digest; latency = 64/R+1 cycles.
- Re-first: send block1 of the two-block vector, then "abc" with first=1, last=1 → digest equals the "abc" result.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and FIPS 180-4 helper functions.
package sha256_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FINAL, OUT} state_t;

  localparam logic [255:0] H0 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  // Word-wise modulo-2^32 addition of two packed 8-word hash values.
  function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
    return r;
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round; state packed as {a,b,c,d,e,f,g,h}.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [255:0] state_in,
  input  logic [31:0]  w,
  input  logic [31:0]  k,
  output logic [255:0] state_out
);

  logic [31:0] a, b, c, d, e, f, g, h;
  logic [31:0] t1, t2;

  assign {a, b, c, d, e, f, g, h} = state_in;
  assign t1 = h + big_sigma1(e) + ch(e, f, g) + k + w;
  assign t2 = big_sigma0(a) + maj(a, b, c);
  assign state_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_block_sequencer.sv
// Multi-block SHA-256 engine: folded round datapath, cross-block chaining and
// valid/ready handshakes on both the block input and the digest output.
module sha256_block_sequencer
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
)
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [255:0] dig_data,
  output logic         busy
);

  localparam int RUN_CYCLES = 64 / ROUNDS_PER_CYCLE;
  localparam logic [5:0] RUN_LAST = 6'((RUN_CYCLES - 1) * ROUNDS_PER_CYCLE);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4 ||
        ROUNDS_PER_CYCLE == 8 || ROUNDS_PER_CYCLE == 16)) begin : g_bad_fold
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  state_t        state, next_state;
  logic [255:0]  h;
  logic [255:0]  v;
  logic [31:0]   w [16];
  logic [5:0]    rnd;
  logic          last_q;
  logic [255:0]  init_hash;
  logic [255:0]  sum_hash;

  // ext[0..15] is the live window; ext[16..] are schedule words derived this cycle.
  logic [31:0]   ext   [16 + ROUNDS_PER_CYCLE];
  logic [255:0]  chain [ROUNDS_PER_CYCLE + 1];

  assign init_hash = blk_first ? H0 : h;
  assign sum_hash  = add_words(h, v);
  assign chain[0]  = v;

  for (genvar j = 0; j < 16; j++) begin : g_window
    assign ext[j] = w[j];
  end

  for (genvar i = 0; i < ROUNDS_PER_CYCLE; i++) begin : g_round
    assign ext[16 + i] = small_sigma1(ext[14 + i]) + ext[9 + i] + small_sigma0(ext[1 + i]) + ext[i];

    sha256_round u_round (
      .state_in  (chain[i]),
      .w         (ext[i]),
      .k         (K[rnd + 6'(i)]),
      .state_out (chain[i + 1])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    blk_ready  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        blk_ready = 1'b1;
        busy      = 1'b0;
        if (blk_valid) next_state = RUN;
      end
      RUN:     if (rnd == RUN_LAST) next_state = FINAL;
      FINAL:   next_state = last_q ? OUT : IDLE;
      OUT:     if (dig_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Working variables and chaining register share the same seed on block accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h         <= '0;
      v         <= '0;
      rnd       <= '0;
      last_q    <= 1'b0;
      dig_data  <= '0;
      dig_valid <= 1'b0;
      for (int j = 0; j < 16; j++) w[j] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (blk_valid) begin
            h      <= init_hash;
            v      <= init_hash;
            rnd    <= '0;
            last_q <= blk_last;
            for (int j = 0; j < 16; j++) w[j] <= blk_data[511 - 32*j -: 32];
          end
        end
        RUN: begin
          v   <= chain[ROUNDS_PER_CYCLE];
          rnd <= rnd + 6'(ROUNDS_PER_CYCLE);
          for (int j = 0; j < 16; j++) w[j] <= ext[j + ROUNDS_PER_CYCLE];
        end
        FINAL: begin
          h <= sum_hash;
          if (last_q) begin
            dig_data  <= sum_hash;
            dig_valid <= 1'b1;
          end
        end
        OUT: begin
          if (dig_ready) dig_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
